// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  // Sequencer modes: normal issue, waiting on the multi-cycle unit, one-cycle result drain.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_BUSY  = 2'd1,
    MC_DRAIN = 2'd2
  } state_t;

  // Register x0 is hard-wired to zero and never creates a dependency.
  localparam logic [4:0] REG_X0 = 5'd0;

endpackage : pipe_pkg

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use hazard detector: the EX-stage load writes a register that the ID stage reads.
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       lu
);

  // A load into x0 produces nothing to forward, so it never stalls.
  assign lu = mem_read && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));

endmodule : hazard_cmp

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Optional build macro PIPE_PERF_EN adds saturating performance counters
// (load-use stall cycles, IF flush cycles, multi-cycle busy cycles).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int PERF_W     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       MemRead_ex,
  input  logic [4:0] rdAddr_ex,
  input  logic [4:0] rs1Addr_id,
  input  logic [4:0] rs2Addr_id,
  input  logic       Branch,
  input  logic       Jump,
  input  logic       mc_ex,
  input  logic       mc_done,
  output logic       PCWrite,
  output logic       IFWrite,
  output logic       IFFlush,
  output logic       IDEXWrite,
  output logic       IDFlush,
  output logic       EXFlush,
  output logic       PCSrc,
  output logic       mc_go,
  output logic       mc_err
`ifdef PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_lu,
  output logic [PERF_W-1:0] perf_flush,
  output logic [PERF_W-1:0] perf_mc
`endif
);

  localparam int CNT_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] MC_LAST = CNT_W'(MC_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] mc_cnt;
  logic             lu;
  logic             mc_start;

  hazard_cmp u_hazard_cmp (
    .mem_read (MemRead_ex),
    .rd       (rdAddr_ex),
    .rs1      (rs1Addr_id),
    .rs2      (rs2Addr_id),
    .lu       (lu)
  );

  // Pipeline enables/bubbles from the current mode and the hazard priority chain.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    PCWrite   = 1'b1;
    IFWrite   = 1'b1;
    IDEXWrite = 1'b1;
    IFFlush   = 1'b0;
    IDFlush   = 1'b0;
    EXFlush   = 1'b0;
    PCSrc     = 1'b0;
    mc_start  = 1'b0;
    if (!rst_n) begin
      PCWrite   = 1'b0;
      IFWrite   = 1'b0;
      IDEXWrite = 1'b0;
      IFFlush   = 1'b1;
      IDFlush   = 1'b1;
      EXFlush   = 1'b1;
    end else if (state == MC_BUSY) begin
      PCWrite   = 1'b0;
      IFWrite   = 1'b0;
      IDEXWrite = 1'b0;
      EXFlush   = 1'b1;
    end else if ((state == RUN) && mc_ex) begin
      // Entering RUN->MC_BUSY is the only issue point, so one start per op.
      mc_start  = 1'b1;
      PCWrite   = 1'b0;
      IFWrite   = 1'b0;
      IDEXWrite = 1'b0;
      EXFlush   = 1'b1;
    end else if (lu) begin
      // Branch operands may depend on the load, so the redirect waits a cycle.
      PCWrite = 1'b0;
      IFWrite = 1'b0;
      IDFlush = 1'b1;
    end else if (Branch || Jump) begin
      PCSrc   = 1'b1;
      IFFlush = 1'b1;
    end
  end

  // Mode sequencer, multi-cycle start pulse, busy timer and sticky timeout flag.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state  <= RUN;
      mc_go  <= 1'b0;
      mc_err <= 1'b0;
      mc_cnt <= '0;
    end else begin
      mc_go <= mc_start;
      case (state)
        RUN: begin
          mc_cnt <= '0;
          if (mc_start) state <= MC_BUSY;
        end
        MC_BUSY: begin
          if (mc_done) begin
            state <= MC_DRAIN;
          end else if (mc_cnt == MC_LAST) begin
            mc_err <= 1'b1;
            state  <= MC_DRAIN;
          end else begin
            mc_cnt <= mc_cnt + 1'b1;
          end
        end
        MC_DRAIN: begin
          mc_cnt <= '0;
          state  <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_EN
  // Saturating event counters; IDFlush is raised only by a load-use stall outside reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lu    <= '0;
      perf_flush <= '0;
      perf_mc    <= '0;
    end else begin
      if (IDFlush && (perf_lu != '1))       perf_lu    <= perf_lu + 1'b1;
      if (IFFlush && (perf_flush != '1))    perf_flush <= perf_flush + 1'b1;
      if ((state == MC_BUSY) && (perf_mc != '1)) perf_mc <= perf_mc + 1'b1;
    end
  end
`endif

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MC_TIMEOUT = 64;
  localparam int PERF_W     = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       MemRead_ex, Branch, Jump, mc_ex, mc_done;
  logic [4:0] rdAddr_ex, rs1Addr_id, rs2Addr_id;
  logic       PCWrite, IFWrite, IFFlush, IDEXWrite, IDFlush, EXFlush, PCSrc, mc_go, mc_err;
`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] perf_lu, perf_flush, perf_mc;
  int unsigned       m_plu, m_pflush, m_pmc;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  pipe_hazard_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id), .Branch(Branch), .Jump(Jump),
    .mc_ex(mc_ex), .mc_done(mc_done), .PCWrite(PCWrite), .IFWrite(IFWrite),
    .IFFlush(IFFlush), .IDEXWrite(IDEXWrite), .IDFlush(IDFlush), .EXFlush(EXFlush),
    .PCSrc(PCSrc), .mc_go(mc_go), .mc_err(mc_err)
`ifdef PIPE_PERF_EN
    , .perf_lu(perf_lu), .perf_flush(perf_flush), .perf_mc(perf_mc)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: is a multi-cycle op outstanding, how long has it run, drain pending.
  bit m_busy, m_drain, m_go, m_err;
  int m_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit model_lu();
    return MemRead_ex && (rdAddr_ex != 5'd0) &&
           ((rdAddr_ex == rs1Addr_id) || (rdAddr_ex == rs2Addr_id));
  endfunction

  // {PCWrite, IFWrite, IDEXWrite, IFFlush, IDFlush, EXFlush, PCSrc}
  function automatic logic [6:0] exp_ctrl();
    if (!rst_n)                 return 7'b000_111_0;
    if (m_busy)                 return 7'b000_001_0;
    if (!m_drain && mc_ex)      return 7'b000_001_0;
    if (model_lu())             return 7'b111_010_0 & 7'b001_111_1;
    if (Branch || Jump)         return 7'b111_100_1;
    return 7'b111_000_0;
  endfunction

  task automatic settle();
    #1;
    check("ctrl", 32'({PCWrite, IFWrite, IDEXWrite, IFFlush, IDFlush, EXFlush, PCSrc}),
          32'(exp_ctrl()));
    check("mc_go", 32'(mc_go), 32'(m_go));
    check("mc_err", 32'(mc_err), 32'(m_err));
`ifdef PIPE_PERF_EN
    check("perf_lu", 32'(perf_lu), m_plu);
    check("perf_flush", 32'(perf_flush), m_pflush);
    check("perf_mc", 32'(perf_mc), m_pmc);
`endif
  endtask

  task automatic tick();
    logic [6:0] e;
    bit         start;
    e = exp_ctrl();
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_drain = 0; m_go = 0; m_err = 0; m_cycles = 0;
`ifdef PIPE_PERF_EN
      m_plu = 0; m_pflush = 0; m_pmc = 0;
`endif
    end else begin
`ifdef PIPE_PERF_EN
      if (e[2]) m_plu++;
      if (e[3]) m_pflush++;
      if (m_busy) m_pmc++;
`endif
      start = !m_busy && !m_drain && mc_ex;
      if (m_busy) begin
        m_cycles++;
        if (mc_done) begin
          m_busy = 0; m_drain = 1;
        end else if (m_cycles == MC_TIMEOUT) begin
          m_err = 1; m_busy = 0; m_drain = 1;
        end
      end else if (m_drain) begin
        m_drain = 0;
      end else if (mc_ex) begin
        m_busy = 1; m_cycles = 0;
      end
      m_go = start;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    MemRead_ex = 0; rdAddr_ex = 0; rs1Addr_id = 0; rs2Addr_id = 0;
    Branch = 0; Jump = 0; mc_ex = 0; mc_done = 0;
  endtask

  initial begin
    int busy_seen, go_seen, n_to_err;
    bit err_seen;
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    settle(); tick();
    settle();
    check("rst_pcwrite", 32'(PCWrite), 32'd0);
    tick();
    rst_n = 1;
    settle();
    check("run_default", 32'({PCWrite, IFWrite, IDEXWrite, IFFlush, IDFlush}), 32'b11100);
    tick();

    // Load-use on rs1.
    MemRead_ex = 1; rdAddr_ex = 5; rs1Addr_id = 5; rs2Addr_id = 7;
    settle();
    check("t1_lu_stall", 32'({PCWrite, IFWrite, IDFlush}), 32'b001);
    tick();
    // Same load into x0: no dependency.
    rdAddr_ex = 0; rs1Addr_id = 0;
    settle();
    check("t2_x0_nostall", 32'({PCWrite, IFWrite, IDEXWrite, IDFlush}), 32'b1110);
    tick();
    idle_inputs();

    // Jump redirects for exactly one cycle.
    Jump = 1;
    settle();
    check("t3_jump", 32'({PCSrc, IFFlush}), 32'b11);
    tick();
    Jump = 0;
    settle();
    check("t3_jump_done", 32'({PCSrc, IFFlush}), 32'b00);
    tick();

    // Load-use and branch together: stall first, branch next cycle.
    MemRead_ex = 1; rdAddr_ex = 9; rs2Addr_id = 9; Branch = 1;
    settle();
    check("t4_stall_wins", 32'({PCSrc, PCWrite, IDFlush}), 32'b001);
    tick();
    MemRead_ex = 0; rdAddr_ex = 0;
    settle();
    check("t4_branch_next", 32'({PCSrc, IFFlush}), 32'b11);
    tick();
    idle_inputs();

    // Multi-cycle op finishing on its 10th busy cycle.
    mc_ex = 1;
    settle();
    check("t5_issue", 32'({PCWrite, EXFlush, mc_go}), 32'b010);
    tick();
    busy_seen = 0; go_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      mc_done = (k == 10);
      settle();
      if (!PCWrite) busy_seen++;
      if (mc_go) go_seen++;
      tick();
    end
    mc_done = 0;
    settle();
    check("t5_drain", 32'({PCWrite, IDEXWrite, EXFlush, mc_go}), 32'b1100);
    tick();
    mc_ex = 0;
    settle();
    tick();
    check("t5_busy_cycles", 32'(busy_seen), 32'd10);
    check("t5_go_pulses", 32'(go_seen), 32'd1);

    // Multi-cycle op that never completes: timeout after MC_TIMEOUT busy cycles.
    mc_ex = 1;
    settle(); tick();
    n_to_err = 0; err_seen = 0;
    for (int k = 0; k < 200 && !err_seen; k++) begin
      settle();
      if (mc_err) err_seen = 1;
      else begin
        n_to_err++;
        tick();
      end
    end
    check("t6_err_seen", 32'(err_seen), 32'd1);
    check("t6_timeout_cycles", 32'(n_to_err), 32'(MC_TIMEOUT));
    check("t6_drain_write", 32'(PCWrite), 32'd1);
    tick();
    mc_ex = 0;
    settle();
    check("t6_err_sticky", 32'(mc_err), 32'd1);
    tick();
    rst_n = 0;
    settle(); tick();
    rst_n = 1;
    settle();
    check("t6_err_cleared", 32'(mc_err), 32'd0);
    tick();

    // Randomized traffic, including reset in the middle of busy periods.
    for (int i = 0; i < 4000; i++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      MemRead_ex = $urandom_range(0, 1) == 1;
      rdAddr_ex  = 5'($urandom_range(0, 3));
      rs1Addr_id = 5'($urandom_range(0, 3));
      rs2Addr_id = 5'($urandom_range(0, 3));
      Branch     = $urandom_range(0, 3) == 0;
      Jump       = $urandom_range(0, 5) == 0;
      mc_ex      = $urandom_range(0, 9) == 0;
      mc_done    = $urandom_range(0, 39) == 0;
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
